rv_iopmp_err_queue: RTL and testbench

Error-record queue between the IOPMP checker instances and the register map. Each checker pulses an error record on a violation; the queue round-robin selects at most one record per cycle and stores it in a DEPTH-entry FIFO. It presents the oldest record to the regmap until software pops it, drives the wired-signal interrupt, and accounts for every record it could not store.

---
 rtl/rv_iopmp_err_queue.sv | 168 ++++++++++++++++
 tb/tb_rv_iopmp_err_queue.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_iopmp_err_queue.sv
// Error-record queue: round-robin picks one checker violation per cycle into a FIFO,
// presents the oldest record to the regmap, raises the wired interrupt and counts drops.
module rv_iopmp_err_queue #(
    parameter int ADDR_WIDTH          = 64,
    parameter int SID_WIDTH           = 8,
    parameter int NUMBER_TL_INSTANCES = 2,
    parameter int DEPTH               = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NUMBER_TL_INSTANCES-1:0]          err_valid_i,
    input  logic [NUMBER_TL_INSTANCES*ADDR_WIDTH-1:0] err_addr_i,
    input  logic [NUMBER_TL_INSTANCES*SID_WIDTH-1:0]  err_sid_i,
    input  logic [NUMBER_TL_INSTANCES*2-1:0]        err_ttype_i,
    input  logic [NUMBER_TL_INSTANCES*3-1:0]        err_etype_i,
    output logic                                    rec_valid_o,
    output logic [ADDR_WIDTH-1:0]                   rec_addr_o,
    output logic [SID_WIDTH-1:0]                    rec_sid_o,
    output logic [1:0]                              rec_ttype_o,
    output logic [2:0]                              rec_etype_o,
    output logic [((NUMBER_TL_INSTANCES > 1) ? $clog2(NUMBER_TL_INSTANCES) : 1)-1:0] rec_inst_o,
    input  logic                                    rec_pop_i,
    input  logic                                    ie_i,
    output logic                                    wsi_o,
    output logic                                    overflow_o,
    output logic [7:0]                              drop_cnt_o,
    input  logic                                    clear_i
);

    localparam int N      = NUMBER_TL_INSTANCES;
    localparam int INST_W = (N > 1) ? $clog2(N) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [INST_W-1:0]     rr_r;
    logic [PTR_W-1:0]      wptr_r;
    logic [PTR_W-1:0]      rptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  wsi_r;
    logic                  overflow_r;
    logic [7:0]            drop_cnt_r;

    logic [ADDR_WIDTH-1:0] mem_addr_r  [DEPTH];
    logic [SID_WIDTH-1:0]  mem_sid_r   [DEPTH];
    logic [1:0]            mem_ttype_r [DEPTH];
    logic [2:0]            mem_etype_r [DEPTH];
    logic [INST_W-1:0]     mem_inst_r  [DEPTH];

    logic                  grant_s;
    logic [INST_W-1:0]     winner_s;
    logic [INST_W-1:0]     rr_next_s;
    logic [31:0]           nvalid_s;
    logic [31:0]           drop_s;
    logic [31:0]           cnt_base_s;
    logic [31:0]           cnt_sum_s;
    logic [7:0]            cnt_next_s;
    logic                  rec_valid_s;
    logic                  full_s;
    logic                  pop_s;
    logic                  push_s;
    logic [ADDR_WIDTH-1:0] win_addr_s;
    logic [SID_WIDTH-1:0]  win_sid_s;
    logic [1:0]            win_ttype_s;
    logic [2:0]            win_etype_s;

    // Round-robin search: requesters at or above rr first, then the wrapped lower ones.
    always_comb begin
        grant_s  = 1'b0;
        winner_s = '0;
        nvalid_s = 32'd0;
        for (int i = 0; i < N; i++) begin
            nvalid_s = nvalid_s + 32'(err_valid_i[i]);
            winner_s = (!grant_s && err_valid_i[i] && (i >= int'(rr_r))) ? INST_W'(i) : winner_s;
            grant_s  = grant_s | (err_valid_i[i] && (i >= int'(rr_r)));
        end
        for (int i = 0; i < N; i++) begin
            winner_s = (!grant_s && err_valid_i[i] && (i < int'(rr_r))) ? INST_W'(i) : winner_s;
            grant_s  = grant_s | (err_valid_i[i] && (i < int'(rr_r)));
        end
        rr_next_s = (winner_s == INST_W'(N - 1)) ? '0 : winner_s + INST_W'(1);
    end

    // Push/pop decisions and per-cycle drop accounting with saturation.
    always_comb begin
        rec_valid_s = (count_r != '0);
        full_s      = (count_r == FULL_CNT);
        pop_s       = rec_pop_i & rec_valid_s;
        push_s      = grant_s & (~full_s | pop_s);
        drop_s      = nvalid_s - 32'(push_s);
        cnt_base_s  = clear_i ? 32'd0 : {24'd0, drop_cnt_r};
        cnt_sum_s   = cnt_base_s + drop_s;
        cnt_next_s  = (cnt_sum_s > 32'd255) ? 8'hFF : cnt_sum_s[7:0];
        win_addr_s  = err_addr_i[int'(winner_s)*ADDR_WIDTH +: ADDR_WIDTH];
        win_sid_s   = err_sid_i[int'(winner_s)*SID_WIDTH +: SID_WIDTH];
        win_ttype_s = err_ttype_i[int'(winner_s)*2 +: 2];
        win_etype_s = err_etype_i[int'(winner_s)*3 +: 3];
    end

    // Control state: arbitration pointer, FIFO pointers, interrupt and drop tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_r       <= '0;
            wptr_r     <= '0;
            rptr_r     <= '0;
            count_r    <= '0;
            wsi_r      <= 1'b0;
            overflow_r <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else begin
            if (grant_s) begin
                rr_r <= rr_next_s;
            end
            if (push_s) begin
                wptr_r <= wptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
            wsi_r   <= rec_valid_s & ie_i;
            // A drop in the same cycle as clear wins: overflow stays set.
            if (drop_s != 32'd0) begin
                overflow_r <= 1'b1;
            end else if (clear_i) begin
                overflow_r <= 1'b0;
            end
            if (clear_i || (drop_s != 32'd0)) begin
                drop_cnt_r <= cnt_next_s;
            end
        end
    end

    // Record storage; contents are qualified by the occupancy count so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_addr_r[wptr_r]  <= win_addr_s;
            mem_sid_r[wptr_r]   <= win_sid_s;
            mem_ttype_r[wptr_r] <= win_ttype_s;
            mem_etype_r[wptr_r] <= win_etype_s;
            mem_inst_r[wptr_r]  <= winner_s;
        end
    end

    // Head presentation, forced to zero while empty.
    always_comb begin
        rec_valid_o = rec_valid_s;
        rec_addr_o  = '0;
        rec_sid_o   = '0;
        rec_ttype_o = 2'd0;
        rec_etype_o = 3'd0;
        rec_inst_o  = '0;
        if (rec_valid_s) begin
            rec_addr_o  = mem_addr_r[rptr_r];
            rec_sid_o   = mem_sid_r[rptr_r];
            rec_ttype_o = mem_ttype_r[rptr_r];
            rec_etype_o = mem_etype_r[rptr_r];
            rec_inst_o  = mem_inst_r[rptr_r];
        end else begin
            rec_addr_o  = '0;
        end
    end

    assign wsi_o      = wsi_r;
    assign overflow_o = overflow_r;
    assign drop_cnt_o = drop_cnt_r;

endmodule

// File: tb/tb_rv_iopmp_err_queue.sv
// Self-checking bench for rv_iopmp_err_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_rv_iopmp_err_queue;

    localparam int AW = 64;
    localparam int SW = 8;
    localparam int N  = 2;
    localparam int D  = 4;
    localparam int IW = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      err_valid = '0;
    logic [N*AW-1:0]   err_addr = '0;
    logic [N*SW-1:0]   err_sid = '0;
    logic [N*2-1:0]    err_ttype = '0;
    logic [N*3-1:0]    err_etype = '0;
    logic              rec_valid;
    logic [AW-1:0]     rec_addr;
    logic [SW-1:0]     rec_sid;
    logic [1:0]        rec_ttype;
    logic [2:0]        rec_etype;
    logic [IW-1:0]     rec_inst;
    logic              rec_pop = 1'b0;
    logic              ie = 1'b0;
    logic              wsi;
    logic              overflow;
    logic [7:0]        drop_cnt;
    logic              clear = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [SW-1:0] sid;
        logic [1:0]    ttype;
        logic [2:0]    etype;
        int            inst;
    } rec_t;

    rec_t mq[$];
    int   m_rr  = 0;
    int   m_cnt = 0;
    bit   m_ovf = 1'b0;
    bit   m_wsi = 1'b0;

    rv_iopmp_err_queue #(
        .ADDR_WIDTH(AW), .SID_WIDTH(SW), .NUMBER_TL_INSTANCES(N), .DEPTH(D)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .err_valid_i(err_valid), .err_addr_i(err_addr), .err_sid_i(err_sid),
        .err_ttype_i(err_ttype), .err_etype_i(err_etype),
        .rec_valid_o(rec_valid), .rec_addr_o(rec_addr), .rec_sid_o(rec_sid),
        .rec_ttype_o(rec_ttype), .rec_etype_o(rec_etype), .rec_inst_o(rec_inst),
        .rec_pop_i(rec_pop), .ie_i(ie), .wsi_o(wsi),
        .overflow_o(overflow), .drop_cnt_o(drop_cnt), .clear_i(clear)
    );

    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [SW-1:0] s,
                           input logic [1:0] t, input logic [2:0] e);
        err_valid[i]         = 1'b1;
        err_addr[i*AW +: AW] = a;
        err_sid[i*SW +: SW]  = s;
        err_ttype[i*2 +: 2]  = t;
        err_etype[i*3 +: 3]  = e;
    endtask

    // Advance the model by one cycle from the current inputs, clock the DUT, release pulses.
    task automatic step();
        int   nv;
        int   win;
        int   c;
        bit   popok;
        bit   push;
        rec_t r;
        nv  = 0;
        win = -1;
        for (int k = 0; k < N; k++) begin
            if (err_valid[k]) nv++;
        end
        for (int k = 0; k < N; k++) begin
            c = (m_rr + k) % N;
            if (win < 0 && err_valid[c]) win = c;
        end
        popok = rec_pop && (mq.size() > 0);
        push  = (win >= 0) && ((mq.size() < D) || popok);
        m_wsi = (mq.size() > 0) && ie;
        if (popok) void'(mq.pop_front());
        if (push) begin
            r.addr  = err_addr[win*AW +: AW];
            r.sid   = err_sid[win*SW +: SW];
            r.ttype = err_ttype[win*2 +: 2];
            r.etype = err_etype[win*3 +: 3];
            r.inst  = win;
            mq.push_back(r);
        end
        if (win >= 0) m_rr = (win + 1) % N;
        if (clear) begin
            m_cnt = 0;
            m_ovf = 1'b0;
        end
        if (nv - int'(push) > 0) begin
            m_cnt = m_cnt + nv - int'(push);
            if (m_cnt > 255) m_cnt = 255;
            m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        err_valid = '0;
        rec_pop   = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if ({rec_valid, wsi, overflow, drop_cnt, rec_addr, rec_sid, rec_inst} !== '0) begin
            fails++;
            $display("FAIL reset_state: valid=%0b wsi=%0b ovf=%0b cnt=%0d addr=%h, required all zero",
                     rec_valid, wsi, overflow, drop_cnt, rec_addr);
        end
    endtask

    task automatic test_single_push();
        ie = 1'b1;
        set_req(1, 64'h8000_0040, 8'd3, 2'd2, 3'd1);
        step();
        tests++;
        if ({rec_valid, rec_inst, rec_addr, rec_sid, rec_ttype, rec_etype, wsi} !==
            {1'b1, 1'b1, 64'h8000_0040, 8'd3, 2'd2, 3'd1, 1'b0}) begin
            fails++;
            $display("FAIL single_head: valid=%0b inst=%0d addr=%h sid=%0d tt=%0d et=%0d wsi=%0b, required 1 1 8000_0040 3 2 1 0",
                     rec_valid, rec_inst, rec_addr, rec_sid, rec_ttype, rec_etype, wsi);
        end
        step();
        tests++;
        if (wsi !== 1'b1) begin
            fails++;
            $display("FAIL single_wsi_rise: got %0b required 1", wsi);
        end
        rec_pop = 1'b1;
        step();
        tests++;
        if (rec_valid !== 1'b0 || rec_addr !== 64'd0) begin
            fails++;
            $display("FAIL single_pop: valid=%0b addr=%h required 0 0", rec_valid, rec_addr);
        end
        step();
        tests++;
        if (wsi !== 1'b0) begin
            fails++;
            $display("FAIL single_wsi_fall: got %0b required 0", wsi);
        end
    endtask

    task automatic test_simultaneous();
        set_req(0, 64'h1000, 8'd10, 2'd1, 3'd2);
        set_req(1, 64'h2000, 8'd11, 2'd3, 3'd4);
        step();
        tests++;
        if ({rec_inst, rec_sid, drop_cnt, overflow} !== {1'b0, 8'd10, 8'd1, 1'b1}) begin
            fails++;
            $display("FAIL simul_first: inst=%0d sid=%0d cnt=%0d ovf=%0b required 0 10 1 1",
                     rec_inst, rec_sid, drop_cnt, overflow);
        end
        set_req(0, 64'h1000, 8'd10, 2'd1, 3'd2);
        set_req(1, 64'h2000, 8'd11, 2'd3, 3'd4);
        step();
        tests++;
        if (drop_cnt !== 8'd2) begin
            fails++;
            $display("FAIL simul_cnt: got %0d required 2", drop_cnt);
        end
        rec_pop = 1'b1;
        step();
        tests++;
        if ({rec_valid, rec_inst, rec_sid, rec_addr} !== {1'b1, 1'b1, 8'd11, 64'h2000}) begin
            fails++;
            $display("FAIL simul_second: valid=%0b inst=%0d sid=%0d addr=%h required 1 1 11 2000",
                     rec_valid, rec_inst, rec_sid, rec_addr);
        end
        rec_pop = 1'b1;
        step();
    endtask

    task automatic test_full();
        logic [SW-1:0] exp_sids [4];
        exp_sids[0] = 8'd21; exp_sids[1] = 8'd22; exp_sids[2] = 8'd23; exp_sids[3] = 8'd25;
        for (int k = 0; k < 4; k++) begin
            set_req(0, 64'(k), 8'(20 + k), 2'd1, 3'd0);
            step();
        end
        set_req(0, 64'hDEAD, 8'd24, 2'd1, 3'd0);
        step();
        tests++;
        if ({rec_sid, drop_cnt, overflow} !== {8'd20, 8'd3, 1'b1}) begin
            fails++;
            $display("FAIL full_drop: sid=%0d cnt=%0d ovf=%0b required 20 3 1", rec_sid, drop_cnt, overflow);
        end
        set_req(0, 64'hBEEF, 8'd25, 2'd2, 3'd0);
        rec_pop = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (rec_valid !== 1'b1 || rec_sid !== exp_sids[k]) begin
                fails++;
                $display("FAIL full_order[%0d]: valid=%0b sid=%0d required 1 %0d", k, rec_valid, rec_sid, exp_sids[k]);
            end
            rec_pop = 1'b1;
            step();
        end
        tests++;
        if (rec_valid !== 1'b0 || drop_cnt !== 8'd3) begin
            fails++;
            $display("FAIL full_drained: valid=%0b cnt=%0d required 0 3", rec_valid, drop_cnt);
        end
    endtask

    task automatic test_wraparound();
        for (int k = 0; k < 10; k++) begin
            set_req(k % 2, 64'(k * 16), 8'(k), 2'd3, 3'(k));
            rec_pop = 1'b1;
            step();
            tests++;
            if (rec_valid !== 1'b1 || rec_sid !== 8'(k) || rec_addr !== 64'(k * 16)) begin
                fails++;
                $display("FAIL wrap[%0d]: valid=%0b sid=%0d addr=%h required 1 %0d %h",
                         k, rec_valid, rec_sid, rec_addr, k, 64'(k * 16));
            end
        end
        rec_pop = 1'b1;
        step();
        tests++;
        if (rec_valid !== 1'b0 || drop_cnt !== 8'd3) begin
            fails++;
            $display("FAIL wrap_end: valid=%0b cnt=%0d required 0 3", rec_valid, drop_cnt);
        end
    endtask

    task automatic test_saturation_clear();
        for (int k = 0; k < 300; k++) begin
            set_req(0, 64'h10, 8'd1, 2'd1, 3'd1);
            set_req(1, 64'h20, 8'd2, 2'd2, 3'd2);
            rec_pop = 1'b1;
            step();
        end
        tests++;
        if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL saturate: cnt=%0d ovf=%0b required 255 1", drop_cnt, overflow);
        end
        set_req(0, 64'h10, 8'd1, 2'd1, 3'd1);
        set_req(1, 64'h20, 8'd2, 2'd2, 3'd2);
        rec_pop = 1'b1;
        clear   = 1'b1;
        step();
        tests++;
        if (drop_cnt !== 8'd1 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL clear_with_drop: cnt=%0d ovf=%0b required 1 1", drop_cnt, overflow);
        end
        clear   = 1'b1;
        rec_pop = 1'b1;
        step();
        tests++;
        if (drop_cnt !== 8'd0 || overflow !== 1'b0 || rec_valid !== 1'b0) begin
            fails++;
            $display("FAIL clear_alone: cnt=%0d ovf=%0b valid=%0b required 0 0 0", drop_cnt, overflow, rec_valid);
        end
    endtask

    task automatic test_random();
        logic [88:0] got;
        logic [88:0] exp;
        rec_t        h;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    set_req(i, {$urandom, $urandom}, 8'($urandom), 2'($urandom_range(1, 3)), 3'($urandom));
                end
            end
            rec_pop = ($urandom_range(0, 2) != 0);
            clear   = ($urandom_range(0, 15) == 0);
            ie      = ($urandom_range(0, 3) != 0);
            step();
            if (mq.size() > 0) begin
                h = mq[0];
            end else begin
                h.addr = '0; h.sid = '0; h.ttype = '0; h.etype = '0; h.inst = 0;
            end
            got = {rec_valid, rec_addr, rec_sid, rec_ttype, rec_etype, rec_inst, wsi, overflow, drop_cnt};
            exp = {mq.size() > 0, h.addr, h.sid, h.ttype, h.etype, IW'(h.inst), m_wsi, m_ovf, 8'(m_cnt)};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL random[%0d]: got %h required %h (valid,addr,sid,tt,et,inst,wsi,ovf,cnt)", k, got, exp);
            end
        end
    endtask

    task automatic test_reset_midop();
        for (int k = 0; k <= D; k++) begin
            rec_pop = 1'b1;
            step();
        end
        set_req(0, 64'hA0, 8'd40, 2'd1, 3'd1);
        set_req(1, 64'hB0, 8'd41, 2'd2, 3'd2);
        step();
        set_req(0, 64'hA1, 8'd42, 2'd1, 3'd1);
        step();
        set_req(1, 64'hB1, 8'd43, 2'd3, 3'd3);
        step();
        tests++;
        if (rec_valid !== 1'b1 || drop_cnt === 8'd0) begin
            fails++;
            $display("FAIL premid_state: valid=%0b cnt=%0d required 1 and nonzero", rec_valid, drop_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (rec_valid !== 1'b0 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: valid=%0b cnt=%0d ovf=%0b required 0 0 0", rec_valid, drop_cnt, overflow);
        end
        mq.delete();
        m_rr  = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
        m_wsi = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_req(1, 64'h77, 8'h77, 2'd2, 3'd5);
        step();
        tests++;
        if ({rec_valid, rec_inst, rec_sid, rec_addr, rec_etype} !== {1'b1, 1'b1, 8'h77, 64'h77, 3'd5}) begin
            fails++;
            $display("FAIL post_reset_push: valid=%0b inst=%0d sid=%h addr=%h et=%0d required 1 1 77 77 5",
                     rec_valid, rec_inst, rec_sid, rec_addr, rec_etype);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_single_push();
        test_simultaneous();
        test_full();
        test_wraparound();
        test_saturation_clear();
        test_random();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
